// File: rtl/game_progress_ctrl.sv
// Game-level sequencer: latches home arrivals, advances stage 1 -> stage 2 -> win,
// handles game over, and keeps the running score and the high score.
module game_progress_ctrl #(
  parameter int LIVES_MAX   = 3,
  parameter int CLEAR_HOLD  = 60,
  parameter int WIN_HOLD    = 180,
  parameter int OVER_HOLD   = 180,
  parameter int HOME_PTS    = 50,
  parameter int STAGE_BONUS = 1000
) (
  input  logic        frame_clk,
  input  logic        Reset,
  input  logic [3:0]  Life,
  input  logic        frogreset,
  input  logic        safe1,
  input  logic        safe2,
  input  logic        safe3,
  input  logic        safe4,
  input  logic        safe5,
  output logic        safe1x,
  output logic        safe2x,
  output logic        safe3x,
  output logic        safe4x,
  output logic        safe5x,
  output logic        stage2x,
  output logic        winreset,
  output logic        winx,
  output logic        gameoverx,
  output logic [15:0] score,
  output logic [15:0] hi_score,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    PLAY        = 2'd0,
    STAGE_CLEAR = 2'd1,
    WIN         = 2'd2,
    GAMEOVER    = 2'd3
  } state_t;

  localparam logic [3:0]  LIVES_MAX_W   = 4'(LIVES_MAX);
  localparam logic [7:0]  CLEAR_LAST    = 8'(CLEAR_HOLD - 1);
  localparam logic [7:0]  WIN_LAST      = 8'(WIN_HOLD - 1);
  localparam logic [7:0]  OVER_LAST     = 8'(OVER_HOLD - 1);
  localparam logic [16:0] HOME_PTS_W    = 17'(HOME_PTS);
  localparam logic [16:0] STAGE_BONUS_W = 17'(STAGE_BONUS);

  state_t      state, state_nx;
  logic [7:0]  hold_cnt, hold_nx;
  logic [4:0]  safe_q, safe_nx;
  logic        stage2_q, stage2_nx;
  logic        winreset_q, winreset_nx;
  logic        winx_q, winx_nx;
  logic        over_q, over_nx;
  logic [15:0] score_q, score_nx;
  logic [15:0] hi_q, hi_nx;

  logic [4:0]  safe_in;
  logic [4:0]  new_homes;
  logic [2:0]  home_cnt;
  logic [16:0] home_add;
  logic [15:0] bonus_score;
  logic        dead;

  // Respawn strobe is informational only.
  logic unused_frogreset;
  assign unused_frogreset = frogreset;

  function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [16:0] b);
    logic [17:0] s;
    s = {2'b00, a} + {1'b0, b};
    return (|s[17:16]) ? 16'hFFFF : s[15:0];
  endfunction

  assign safe_in   = {safe5, safe4, safe3, safe2, safe1};
  assign new_homes = safe_in & ~safe_q;
  assign dead      = (Life == 4'd0) || (Life > LIVES_MAX_W);

  always_comb begin
    home_cnt = 3'd0;
    for (int i = 0; i < 5; i++) begin
      home_cnt = home_cnt + {2'b00, new_homes[i]};
    end
  end

  assign home_add    = {14'd0, home_cnt} * HOME_PTS_W;
  assign bonus_score = sat_add(score_q, STAGE_BONUS_W);

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state      <= PLAY;
      hold_cnt   <= 8'd0;
      safe_q     <= 5'd0;
      stage2_q   <= 1'b0;
      winreset_q <= 1'b0;
      winx_q     <= 1'b0;
      over_q     <= 1'b0;
      score_q    <= 16'd0;
      hi_q       <= 16'd0;
    end else begin
      state      <= state_nx;
      hold_cnt   <= hold_nx;
      safe_q     <= safe_nx;
      stage2_q   <= stage2_nx;
      winreset_q <= winreset_nx;
      winx_q     <= winx_nx;
      over_q     <= over_nx;
      score_q    <= score_nx;
      hi_q       <= hi_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    hold_nx     = hold_cnt + 8'd1;
    safe_nx     = safe_q;
    stage2_nx   = stage2_q;
    winreset_nx = winreset_q;
    winx_nx     = winx_q;
    over_nx     = over_q;
    score_nx    = score_q;
    hi_nx       = hi_q;

    case (state)
      PLAY: begin
        hold_nx = 8'd0;
        // Death wins over everything else arriving in the same frame.
        if (dead) begin
          state_nx = GAMEOVER;
          over_nx  = 1'b1;
          safe_nx  = 5'd0;
          if (score_q > hi_q) hi_nx = score_q;
        end else if (&safe_q) begin
          safe_nx  = 5'd0;
          score_nx = bonus_score;
          if (!stage2_q) begin
            state_nx    = STAGE_CLEAR;
            winreset_nx = 1'b1;
            stage2_nx   = 1'b1;
          end else begin
            state_nx = WIN;
            winx_nx  = 1'b1;
            if (bonus_score > hi_q) hi_nx = bonus_score;
          end
        end else begin
          safe_nx  = safe_q | safe_in;
          score_nx = sat_add(score_q, home_add);
        end
      end

      STAGE_CLEAR: begin
        if (hold_cnt == CLEAR_LAST) begin
          state_nx    = PLAY;
          hold_nx     = 8'd0;
          winreset_nx = 1'b0;
        end
      end

      WIN: begin
        if (hold_cnt == WIN_LAST) begin
          state_nx  = PLAY;
          hold_nx   = 8'd0;
          winx_nx   = 1'b0;
          stage2_nx = 1'b0;
        end
      end

      GAMEOVER: begin
        if (hold_cnt == OVER_LAST) begin
          state_nx  = PLAY;
          hold_nx   = 8'd0;
          over_nx   = 1'b0;
          stage2_nx = 1'b0;
          score_nx  = 16'd0;
        end
      end

      default: begin
        state_nx = PLAY;
        hold_nx  = 8'd0;
      end
    endcase
  end

  assign safe1x    = safe_q[0];
  assign safe2x    = safe_q[1];
  assign safe3x    = safe_q[2];
  assign safe4x    = safe_q[3];
  assign safe5x    = safe_q[4];
  assign stage2x   = stage2_q;
  assign winreset  = winreset_q;
  assign winx      = winx_q;
  assign gameoverx = over_q;
  assign score     = score_q;
  assign hi_score  = hi_q;
  assign state_dbg = state;

endmodule

// File: tb/tb_game_progress_ctrl.sv
// Directed bench for game_progress_ctrl: vector table for per-frame behaviour,
// hand-written sequences for the hold timers, saturation and mid-hold reset.
module tb_game_progress_ctrl;

  logic        frame_clk;
  logic        Reset;
  logic [3:0]  Life;
  logic        frogreset;
  logic        safe1, safe2, safe3, safe4, safe5;
  logic        safe1x, safe2x, safe3x, safe4x, safe5x;
  logic        stage2x, winreset, winx, gameoverx;
  logic [15:0] score, hi_score;
  logic [1:0]  state_dbg;

  int checks = 0;
  int errors = 0;

  game_progress_ctrl dut (
    .frame_clk (frame_clk),
    .Reset     (Reset),
    .Life      (Life),
    .frogreset (frogreset),
    .safe1     (safe1),
    .safe2     (safe2),
    .safe3     (safe3),
    .safe4     (safe4),
    .safe5     (safe5),
    .safe1x    (safe1x),
    .safe2x    (safe2x),
    .safe3x    (safe3x),
    .safe4x    (safe4x),
    .safe5x    (safe5x),
    .stage2x   (stage2x),
    .winreset  (winreset),
    .winx      (winx),
    .gameoverx (gameoverx),
    .score     (score),
    .hi_score  (hi_score),
    .state_dbg (state_dbg)
  );

  // Clock / reset block
  initial frame_clk = 1'b0;
  always #5 frame_clk = ~frame_clk;

  typedef struct {
    logic [3:0]  life;
    logic [4:0]  safe;
    logic [4:0]  exp_safex;
    logic [1:0]  exp_state;
    logic        exp_stage2;
    logic        exp_winreset;
    logic        exp_winx;
    logic        exp_over;
    logic [15:0] exp_score;
    logic [15:0] exp_hi;
  } vec_t;

  vec_t tbl[15];

  function automatic vec_t mk(input logic [3:0] life, input logic [4:0] safe,
                              input logic [4:0] sx, input logic [1:0] st,
                              input logic s2, input logic wr, input logic wx,
                              input logic ov, input logic [15:0] sc,
                              input logic [15:0] hi);
    vec_t v;
    v.life = life; v.safe = safe; v.exp_safex = sx; v.exp_state = st;
    v.exp_stage2 = s2; v.exp_winreset = wr; v.exp_winx = wx; v.exp_over = ov;
    v.exp_score = sc; v.exp_hi = hi;
    return v;
  endfunction

  // Driver tasks
  task automatic step();
    @(posedge frame_clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] life, input logic [4:0] safe);
    Life = life;
    {safe5, safe4, safe3, safe2, safe1} = safe;
  endtask

  // Scoreboard
  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_vec(input string tag, input vec_t v);
    chk({tag, " safex"},    {11'd0, safe5x, safe4x, safe3x, safe2x, safe1x}, {11'd0, v.exp_safex});
    chk({tag, " state"},    {14'd0, state_dbg}, {14'd0, v.exp_state});
    chk({tag, " stage2x"},  {15'd0, stage2x},   {15'd0, v.exp_stage2});
    chk({tag, " winreset"}, {15'd0, winreset},  {15'd0, v.exp_winreset});
    chk({tag, " winx"},     {15'd0, winx},      {15'd0, v.exp_winx});
    chk({tag, " gameover"}, {15'd0, gameoverx}, {15'd0, v.exp_over});
    chk({tag, " score"},    score,              v.exp_score);
    chk({tag, " hi_score"}, hi_score,           v.exp_hi);
  endtask

  task automatic apply_range(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      drive(tbl[i].life, tbl[i].safe);
      step();
      chk_vec($sformatf("vec%0d", i), tbl[i]);
    end
  endtask

  // which: 0 winreset, 1 winx, 2 gameoverx
  task automatic run_hold(input int frames, input int which,
                          input logic [3:0] life_hold, input logic [4:0] safe_hold);
    logic strobe;
    drive(life_hold, safe_hold);
    for (int i = 1; i < frames; i++) begin
      step();
      strobe = (which == 0) ? winreset : (which == 1) ? winx : gameoverx;
      chk($sformatf("hold%0d f%0d strobe", which, i), {15'd0, strobe}, 16'd1);
      chk($sformatf("hold%0d f%0d safex", which, i),
          {11'd0, safe5x, safe4x, safe3x, safe2x, safe1x}, 16'd0);
    end
    drive(4'd3, 5'd0);
    step();
    strobe = (which == 0) ? winreset : (which == 1) ? winx : gameoverx;
    chk($sformatf("hold%0d exit strobe", which), {15'd0, strobe}, 16'd0);
    chk($sformatf("hold%0d exit state", which), {14'd0, state_dbg}, 16'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    vec_t z;
    z = mk(4'd3, 5'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0);
    chk_vec(tag, z);
  endtask

  task automatic async_reset(input string tag);
    #2;
    Reset = 1'b1;
    #1;
    chk_all_zero(tag);
    step();
    Reset = 1'b0;
    drive(4'd3, 5'd0);
  endtask

  logic [16:0] model_score;

  initial begin
    tbl[0]  = mk(4'd3,  5'b00100, 5'b00100, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd50,   16'd0);
    tbl[1]  = mk(4'd3,  5'b00000, 5'b00100, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd50,   16'd0);
    tbl[2]  = mk(4'd3,  5'b00100, 5'b00100, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd50,   16'd0);
    tbl[3]  = mk(4'd3,  5'b00001, 5'b00101, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd100,  16'd0);
    tbl[4]  = mk(4'd3,  5'b00010, 5'b00111, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd150,  16'd0);
    tbl[5]  = mk(4'd3,  5'b11000, 5'b11111, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd250,  16'd0);
    tbl[6]  = mk(4'd3,  5'b00000, 5'b00000, 2'd1, 1'b1, 1'b1, 1'b0, 1'b0, 16'd1250, 16'd0);
    tbl[7]  = mk(4'd3,  5'b00011, 5'b00011, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd1350, 16'd0);
    tbl[8]  = mk(4'd3,  5'b11100, 5'b11111, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd1500, 16'd0);
    tbl[9]  = mk(4'd3,  5'b00000, 5'b00000, 2'd2, 1'b1, 1'b0, 1'b1, 1'b0, 16'd2500, 16'd2500);
    tbl[10] = mk(4'd1,  5'b00001, 5'b00001, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd2550, 16'd2500);
    tbl[11] = mk(4'd0,  5'b00010, 5'b00000, 2'd3, 1'b0, 1'b0, 1'b0, 1'b1, 16'd2550, 16'd2550);
    tbl[12] = mk(4'd3,  5'b11101, 5'b11101, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd200,  16'd2550);
    tbl[13] = mk(4'd0,  5'b00010, 5'b00000, 2'd3, 1'b0, 1'b0, 1'b0, 1'b1, 16'd200,  16'd2550);
    tbl[14] = mk(4'd15, 5'b00000, 5'b00000, 2'd3, 1'b0, 1'b0, 1'b0, 1'b1, 16'd0,    16'd0);

    Reset = 1'b1;
    frogreset = 1'b0;
    drive(4'd3, 5'd0);
    step();
    step();
    chk_all_zero("reset");
    Reset = 1'b0;

    // Stage 1: single home, repeat pulse, multi-home frame, clear
    apply_range(0, 6);
    run_hold(60, 0, 4'd3, 5'b11111);
    chk("clear exit stage2x", {15'd0, stage2x}, 16'd1);
    chk("clear exit score", score, 16'd1250);
    chk("clear exit safex", {11'd0, safe5x, safe4x, safe3x, safe2x, safe1x}, 16'd0);

    // Stage 2 win
    apply_range(7, 9);
    run_hold(180, 1, 4'd3, 5'b00000);
    chk("win exit stage2x", {15'd0, stage2x}, 16'd0);
    chk("win exit score", score, 16'd2500);
    chk("win exit hi", hi_score, 16'd2500);

    // Lives run out
    apply_range(10, 11);
    run_hold(180, 2, 4'd15, 5'b00000);
    chk("over exit score", score, 16'd0);
    chk("over exit stage2x", {15'd0, stage2x}, 16'd0);
    chk("over exit hi", hi_score, 16'd2550);

    // Death in the same frame as a home arrival
    apply_range(12, 13);
    repeat (5) step();
    async_reset("reset mid gameover");

    // Wrapped life count
    apply_range(14, 14);
    async_reset("reset after wrap");

    // Saturation: each full game adds 2500
    model_score = 17'd0;
    for (int g = 0; g < 27; g++) begin
      drive(4'd3, 5'b11111); step();
      drive(4'd3, 5'b00000); step();
      repeat (60) step();
      drive(4'd3, 5'b11111); step();
      drive(4'd3, 5'b00000); step();
      repeat (180) step();
      model_score = model_score + 17'd2500;
      if (model_score > 17'h0FFFF) model_score = 17'h0FFFF;
      chk($sformatf("game%0d score", g), score, model_score[15:0]);
    end
    chk("sat hi", hi_score, 16'hFFFF);

    // Reset 10 frames into a win hold
    drive(4'd3, 5'b11111); step();
    drive(4'd3, 5'b00000); step();
    repeat (60) step();
    drive(4'd3, 5'b11111); step();
    drive(4'd3, 5'b00000); step();
    chk("final win entry", {15'd0, winx}, 16'd1);
    repeat (10) step();
    async_reset("reset mid win");
    step();
    chk_all_zero("after release");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/game_progress_ctrl.md
Name: game_progress_ctrl

Overview:
- Game-level sequencer directly downstream of the hit/home detection stage.
- Consumes the per-frame `Life` count and the five `safeN` home-arrival flags. Drives back the control strobes that detection reacts to: `gameoverx`, `winx`, `winreset`, `stage2x`, and the latched home-occupied flags `safe1x`..`safe5x`.
- Also keeps the running score and the high score for the HUD/sprite stage.

Parameters:
- LIVES_MAX, 3, nominal life count; a `Life` value above this is treated as a wrapped (dead) count.
- CLEAR_HOLD, 60, frames `winreset` is held after stage 1 is cleared.
- WIN_HOLD, 180, frames `winx` is held after stage 2 is cleared.
- OVER_HOLD, 180, frames `gameoverx` is held after lives run out.
- HOME_PTS, 50, score added per newly filled home.
- STAGE_BONUS, 1000, score added on each stage clear.

Ports:
- frame_clk  in  1  frame-rate clock, shared with detection.
- Reset  in  1  asynchronous, active-high reset.
- Life  in  4  remaining lives from detection.
- frogreset  in  1  frog respawn strobe from detection; informational only, not used for state decisions.
- safe1..safe5  in  1 each  home N reached this stage (from detection).
- safe1x..safe5x  out  1 each  home N latched occupied.
- stage2x  out  1  stage 2 active (enables the extra vehicles).
- winreset  out  1  stage-1 clear strobe (held).
- winx  out  1  full-game win strobe (held).
- gameoverx  out  1  game-over strobe (held).
- score  out  16  current score.
- hi_score  out  16  best score since Reset.

Behaviour:
- **Register and reset rules.**
  - All outputs are registered.
  - On Reset (async, immediate): state=PLAY, hold counter=0, all outputs 0.
- **States:** PLAY, STAGE_CLEAR, WIN, GAMEOVER. Hold counter is 8 bits, cleared on every state entry.
- **PLAY.**
  - Each edge, for each N with `safeN==1` and `safeNx==0`: set `safeNx`=1 and add HOME_PTS to score.
    - Several homes in one frame each add HOME_PTS.
  - Dead = `Life==0` or `Life>LIVES_MAX`. Dead → GAMEOVER next edge. Checked first; it overrides home and full-stage processing in the same frame.
  - All five `safeNx` already 1 (registered values) and not dead:
    - `stage2x==0` → STAGE_CLEAR.
    - `stage2x==1` → WIN.
    - score += STAGE_BONUS in both cases.
  - So a fifth home entered at edge k triggers the transition at edge k+1.
- **STAGE_CLEAR.**
  - `winreset`=1 throughout.
  - On entry: `safe1x`..`safe5x` cleared; `stage2x` set to 1.
  - After CLEAR_HOLD frames (counter reaches CLEAR_HOLD-1) → PLAY with `winreset`=0 on that edge.
  - `safeN` inputs are ignored in this state.
- **WIN.**
  - `winx`=1 throughout; `safeNx` cleared on entry.
  - hi_score updated on entry if score > hi_score (the compare includes the bonus just added).
  - After WIN_HOLD frames → PLAY with `stage2x`=0. Score is retained.
- **GAMEOVER.**
  - `gameoverx`=1 throughout; `safeNx` cleared on entry.
  - hi_score updated on entry if score > hi_score.
  - After OVER_HOLD frames → PLAY with `stage2x`=0 and score=0.
  - `Life` is ignored in this state; detection restores it to 3 while `gameoverx` is high.
- **Exclusivity:** at most one of `winreset`, `winx`, `gameoverx` is high in any cycle.
- **Score arithmetic:** 16-bit unsigned, saturating at 0xFFFF on every add.
- **Reset mid-hold:** returns to PLAY immediately; strobes drop asynchronously.

Test Plan:
- Reset, Life=3, pulse safe3=1 for 1 frame → next edge safe3x=1 and score=50; a repeated safe3 pulse leaves score at 50.
- Raise safe1..safe5 in consecutive frames with stage2x=0 → score=250. One edge after safe5x=1: winreset=1, stage2x=1, all safeNx=0, score=1250. winreset drops exactly 60 frames later.
- From stage 2, fill all five homes → winx=1 for 180 frames, hi_score=2500 (1250+250+1000). Afterwards stage2x=0 and score stays 2500.
- In PLAY, drive Life 1→0 → gameoverx=1 next edge and held 180 frames; hi_score updated if greater; then score=0, stage2x=0, state PLAY.
- Same frame: Life=0 and safe2 rising with four homes already set → GAMEOVER taken; safe2x stays 0, no HOME_PTS added, no stage clear.
- Life=15 (wrap) → GAMEOVER. Assert Reset 10 frames into WIN → winx=0 immediately, all outputs 0, hi_score=0.
